fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage. Owns the PC and drives the 4 KB sync-read instruction RAM.
//  The RAM has 1-cycle registered read latency.
//  Returns {pc, instr} pairs to decode over a valid/ready handshake.
//  Accepts redirects (branch/jump/trap) that flush all in-flight fetches.
// PARAMETERS
//  RESET_PC   32'h0000_0000  first fetch address after reset
//  XLEN       32             address/instruction width
// PORTS
//  clk             in   1     rising-edge clock
//  rst_n           in   1     asynchronous reset, active-low
//  imem_addr       out  XLEN  byte address to RAM; RAM samples it at posedge
//  imem_we         out  1     RAM write enable; tied 0
//  imem_wdata      out  XLEN  RAM write data; tied 0
//  imem_rdata      in   XLEN  RAM read data; valid the cycle after the address is sampled
//  redirect_valid  in   1     1-cycle pulse: restart fetch at redirect_pc
//  redirect_pc     in   XLEN  redirect target
//  out_valid       out  1     out_pc/out_instr hold a fetched instruction
//  out_ready       in   1     decode accepts; transfer = out_valid & out_ready
//  out_pc          out  XLEN  PC of out_instr
//  out_instr       out  XLEN  fetched instruction word
//  fetch_fault     out  1     misaligned redirect seen (feature-dependent)
// BEHAVIOUR
//  Reset values
//   fetch_pc = RESET_PC.
//   out_valid, skid_valid, inflight_valid, fetch_fault = 0.
//   out_pc = 0; out_instr = NOP (32'h0000_0013).
//  Address
//   imem_addr = redirect_valid ? redirect_pc : fetch_pc (combinational).
//  Issue
//   occ = out_valid + skid_valid + inflight_valid - (out_valid & out_ready).
//   issue = (occ < 2), or redirect_valid.
//   On issue: inflight_valid <= 1, inflight_pc <= imem_addr, fetch_pc <= imem_addr + 4.
//   fetch_pc increments mod 2^32; no halt at the 4 KB RAM boundary.
//   No issue: fetch_pc holds; inflight_valid <= 0.
//  Return
//   When inflight_valid, imem_rdata pairs with inflight_pc.
//   Written to the out regs if (!out_valid | out_ready) & !skid_valid; otherwise to skid.
//   On a pop with skid_valid, skid moves to the out regs and the return goes into skid.
//   Order is strictly preserved; no entry is ever dropped or duplicated.
//  Throughput and latency
//   Sustained 1 instr/cycle while out_ready = 1.
//   out_ready low: at most 2 entries held (out + skid); issue stops before overflow.
//   First out_valid is on the 2nd posedge after rst_n deasserts (instr @ RESET_PC).
//   Redirect at cycle N gives out_valid with out_pc = target at cycle N+2.
//  Redirect
//   Clears out_valid and skid_valid; the in-flight return is discarded.
//   Redirect wins over a simultaneous handshake: that transfer still occurs and decode
//   must drop it.
//  Reset mid-operation: all valids clear immediately (async); no partial transfer.
// CONFIGURATION
//  FETCH_MISALIGN_CHK_EN defined
//   Redirect with redirect_pc[1:0] != 0: flush as normal, no issue.
//   Set fetch_fault = 1 (sticky) and halt issue until the next aligned redirect,
//   which clears fetch_fault.
//  FETCH_MISALIGN_CHK_EN undefined
//   redirect_pc[1:0] is forced to 2'b00; fetch_fault tied 0.
// STRUCTURE
//  Package rv32_fetch_pkg: XLEN, NOP_INSTR = 32'h0000_0013, PC_STEP = 4.
//  Sub-module fetch_skid_buf: 1-entry skid plus output register, with valid/ready and
//  flush input.
//  Top level keeps the PC, issue logic and in-flight tracking.
// TESTING
//  1) Reset, RAM[0..2] preloaded, out_ready = 1:
//     out_pc 0,4,8 on consecutive cycles from cycle 2; instr = RAM words.
//  2) out_ready low 5 cycles mid-stream:
//     out_pc holds; no loss or duplication on release; at most 2 RAM issues during the stall.
//  3) redirect_pc = 32'h100 while stream flowing:
//     next out_valid (cycle N+2) has out_pc = 32'h100; the older in-flight PC never appears.
//  4) Redirect coincident with out_valid & out_ready, and redirect during a stall:
//     no stale PC emitted afterwards.
//  5) fetch_pc = 32'hFFFF_FFFC:
//     next out_pc = 32'h0000_0000 (wrap).
//  6) FETCH_MISALIGN_CHK_EN, redirect_pc = 32'h102:
//     fetch_fault = 1, out_valid stays 0; redirect to 32'h200 clears the fault and resumes.

Source files
------------

// File: rtl/rv32_fetch_pkg.sv
// Shared constants for the RV32 instruction-fetch stage.
//   XLEN       address / instruction width
//   NOP_INSTR  canonical NOP (addi x0, x0, 0), held in the output register at reset
//   PC_STEP    byte increment between sequential fetches
package rv32_fetch_pkg;

  localparam int unsigned XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned PC_STEP   = 4;

endpackage : rv32_fetch_pkg

// File: rtl/fetch_skid_buf.sv
// Output register plus one-entry skid buffer for fetched {pc, instr} pairs.
// The upstream issue logic never sends a return that would not fit, so there is
// no in_ready; flush drops both held entries and the return presented with it.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   flush                   discard held entries and the incoming return
//   in_valid/in_pc/in_instr returning RAM word and its PC
//   out_ready               consumer accepts the output entry
//   out_valid/out_pc/out_instr  registered output entry
//   skid_valid              skid entry occupied (feeds upstream occupancy)
module fetch_skid_buf
  import rv32_fetch_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [DW-1:0] in_pc,
  input  logic [DW-1:0] in_instr,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_pc,
  output logic [DW-1:0] out_instr,
  output logic          skid_valid
);

  logic [DW-1:0] skid_pc;
  logic [DW-1:0] skid_instr;
  logic          pop_c;

  assign pop_c = out_valid & out_ready;

  // Returns go to the output register when it frees up and the skid is empty,
  // otherwise to the skid; a pop with a full skid shifts skid -> out first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_pc     <= '0;
      out_instr  <= DW'(NOP_INSTR);
      skid_pc    <= '0;
      skid_instr <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (skid_valid) begin
      if (pop_c) begin
        out_pc     <= skid_pc;
        out_instr  <= skid_instr;
        skid_valid <= in_valid;
        if (in_valid) begin
          skid_pc    <= in_pc;
          skid_instr <= in_instr;
        end
      end
    end else if (!out_valid || out_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_pc    <= in_pc;
        out_instr <= in_instr;
      end
    end else begin
      skid_valid <= in_valid;
      if (in_valid) begin
        skid_pc    <= in_pc;
        skid_instr <= in_instr;
      end
    end
  end

endmodule : fetch_skid_buf

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a sync-read (1-cycle) instruction
// RAM and hands {pc, instr} pairs to decode over valid/ready. Redirects flush
// everything in flight and restart fetch at the target.
// Optional feature macro: FETCH_MISALIGN_CHK_EN
//   defined   - a redirect with target[1:0] != 0 flushes, raises sticky fetch_fault
//               and halts issue until the next aligned redirect clears it
//   undefined - target[1:0] is forced to 0 and fetch_fault is tied low
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   imem_addr/imem_we/imem_wdata     RAM request (addr combinational, write tied off)
//   imem_rdata                       RAM data, one cycle after the address is sampled
//   redirect_valid/redirect_pc       one-cycle restart request and target
//   out_valid/out_ready/out_pc/out_instr  decode handshake
//   fetch_fault                      sticky misaligned-redirect flag
module fetch_unit
  import rv32_fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] imem_addr,
  output logic            imem_we,
  output logic [XLEN-1:0] imem_wdata,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr,
  output logic            fetch_fault
);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] inflight_pc;
  logic            inflight_valid;
  logic            skid_valid;
  logic [XLEN-1:0] redirect_tgt_c;
  logic [XLEN-1:0] addr_c;
  logic            redirect_ok_c;
  logic            halt_c;
  logic            pop_c;
  logic [1:0]      occ_c;
  logic            issue_c;
  logic            ret_valid_c;

`ifdef FETCH_MISALIGN_CHK_EN
  logic fault_q;

  assign redirect_tgt_c = redirect_pc;
  assign redirect_ok_c  = (redirect_pc[1:0] == 2'b00);
  assign halt_c         = fault_q;
  assign fetch_fault    = fault_q;

  // Every redirect re-evaluates the fault: misaligned sets it, aligned clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else if (redirect_valid) begin
      fault_q <= !redirect_ok_c;
    end
  end
`else
  logic unused_redirect_lsb;

  assign redirect_tgt_c      = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];
  assign redirect_ok_c       = 1'b1;
  assign halt_c              = 1'b0;
  assign fetch_fault         = 1'b0;
`endif

  assign addr_c     = redirect_valid ? redirect_tgt_c : fetch_pc;
  assign imem_addr  = addr_c;
  assign imem_we    = 1'b0;
  assign imem_wdata = '0;

  // Entries that will be held after this edge if nothing new were issued;
  // issuing only below 2 guarantees the out+skid pair never overflows.
  assign pop_c   = out_valid & out_ready;
  assign occ_c   = 2'(out_valid) + 2'(skid_valid) + 2'(inflight_valid) - 2'(pop_c);
  assign issue_c = redirect_valid ? redirect_ok_c : ((occ_c < 2'd2) && !halt_c);

  // A return coinciding with a redirect belongs to the old stream.
  assign ret_valid_c = inflight_valid & !redirect_valid;

  // PC and in-flight request tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc       <= RESET_PC;
      inflight_valid <= 1'b0;
      inflight_pc    <= '0;
    end else if (issue_c) begin
      inflight_valid <= 1'b1;
      inflight_pc    <= addr_c;
      fetch_pc       <= addr_c + XLEN'(PC_STEP);
    end else begin
      inflight_valid <= 1'b0;
    end
  end

  fetch_skid_buf #(
    .DW(XLEN)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .in_valid  (ret_valid_c),
    .in_pc     (inflight_pc),
    .in_instr  (imem_rdata),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .skid_valid(skid_valid)
  );

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle-exact directed table from reset, random
// ready/redirect traffic scored against an in-order PC stream model, and an
// asynchronous mid-stream reset.
module tb_fetch_unit;
  import rv32_fetch_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic        imem_we;
  logic [31:0] imem_wdata;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        fetch_fault;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:1023];

  fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (imem_addr),
    .imem_we       (imem_we),
    .imem_wdata    (imem_wdata),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_instr     (out_instr),
    .fetch_fault   (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 4 KB sync-read RAM, word indexed by address bits [11:2].
  always @(posedge clk) imem_rdata <= mem[imem_addr[11:2]];

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    return mem[a[11:2]];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc;
    logic        ef;
  } vec_t;

  localparam int NVEC = 26;
  vec_t tbl [NVEC];

  logic [31:0] exp_pc;
  logic        rdy;
  logic        rv;
  logic [31:0] tgt;
  int          gap;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom();
    mem[0] = 32'h0000_0013;
    mem[1] = 32'h0010_0093;
    mem[2] = 32'h0020_0113;

    // Row i: expected outputs after i posedges from reset release, then inputs
    // for the next edge. Columns: ready, redirect, target, valid, pc, fault.
    tbl[0]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0};
    tbl[1]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0};
    tbl[2]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h0,         1'b0};
    tbl[3]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h4,         1'b0};
    tbl[4]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h8,         1'b0};
    tbl[5]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h8,         1'b0};
    tbl[6]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h8,         1'b0};
    tbl[7]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h8,         1'b0};
    tbl[8]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h8,         1'b0};
    tbl[9]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h8,         1'b0};
    tbl[10] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'hC,         1'b0};
    tbl[11] = '{1'b1, 1'b1, 32'h100,       1'b1, 32'h10,        1'b0};
    tbl[12] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0};
    tbl[13] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h100,       1'b0};
    tbl[14] = '{1'b0, 1'b1, 32'h40,        1'b1, 32'h100,       1'b0};
    tbl[15] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0};
    tbl[16] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h40,        1'b0};
    tbl[17] = '{1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h44,        1'b0};
    tbl[18] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0};
    tbl[19] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 1'b0};
    tbl[20] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h0,         1'b0};
    tbl[21] = '{1'b1, 1'b1, 32'h102,       1'b1, 32'h4,         1'b0};
`ifdef FETCH_MISALIGN_CHK_EN
    tbl[22] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1};
    tbl[23] = '{1'b1, 1'b1, 32'h200,       1'b0, 32'h0,         1'b1};
`else
    tbl[22] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0};
    tbl[23] = '{1'b1, 1'b1, 32'h200,       1'b1, 32'h100,       1'b0};
`endif
    tbl[24] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0};
    tbl[25] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h200,       1'b0};

    // Reset state.
    rst_n          = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_instr", out_instr, NOP_INSTR);
    chk("rst_fault", 32'(fetch_fault), 32'h0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("imem_we", 32'(imem_we), 32'h0);
    chk("imem_wdata", imem_wdata, 32'h0);
    rst_n = 1'b1;

    // Directed table.
    for (int i = 0; i < NVEC; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_fault", i), 32'(fetch_fault), 32'(tbl[i].ef));
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_pc", i), out_pc, tbl[i].epc);
        chk($sformatf("tbl%0d_instr", i), out_instr, ram_word(tbl[i].epc));
      end
      if (i >= 5 && i <= 8) chk($sformatf("tbl%0d_stall_addr", i), imem_addr, 32'h10);
      out_ready      = tbl[i].rdy;
      redirect_valid = tbl[i].rv;
      redirect_pc    = tbl[i].rpc;
    end

    // Random traffic: every accepted entry must be the next PC of the current
    // stream (target, target+4, ...) with the RAM word at that PC.
    exp_pc = '0;
    gap    = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rdy = ($urandom_range(0, 9) < 7);
      rv  = (i == 0) || ($urandom_range(0, 19) == 0);
      tgt = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0;
      if (i > 0) begin
        chk("rnd_fault", 32'(fetch_fault), 32'h0);
        if (!out_valid) gap++;
        else gap = 0;
        chk("rnd_gap", 32'(gap <= 2), 32'h1);
        if (out_valid && rdy && !rv) begin
          chk("rnd_pc", out_pc, exp_pc);
          chk("rnd_instr", out_instr, ram_word(exp_pc));
          exp_pc = exp_pc + 32'd4;
        end
      end
      if (rv) begin
        exp_pc = tgt;
        gap    = 0;
      end
      out_ready      = rdy;
      redirect_valid = rv;
      redirect_pc    = tgt;
    end
    @(negedge clk);
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    repeat (3) @(negedge clk);

    // Asynchronous reset mid-stream, then a clean restart at RESET_PC.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'h0);
    chk("arst_fault", 32'(fetch_fault), 32'h0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("arst_cycle1_valid", 32'(out_valid), 32'h0);
    @(negedge clk);
    chk("arst_cycle2_valid", 32'(out_valid), 32'h1);
    chk("arst_cycle2_pc", out_pc, 32'h0);
    chk("arst_cycle2_instr", out_instr, ram_word(32'h0));
    @(negedge clk);
    chk("arst_cycle3_pc", out_pc, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_fetch_unit
